// File: rtl/core_control_ldst_seq_pkg.sv
// ============================================================================
// Module  : core_control_ldst_seq_pkg
// Brief   : Shared control typedefs and address helpers for the LDM/STM sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package core_control_ldst_seq_pkg;

  typedef enum logic [1:0] {
    LDST_IDLE      = 2'd0,
    LDST_SETUP     = 2'd1,
    LDST_XFER      = 2'd2,
    LDST_WRITEBACK = 2'd3
  } ldst_seq_state;

  localparam logic [31:0] c_WORD_BYTES = 32'd4;

  // Byte span of an N-register block (N in 0..16).
  function automatic logic [31:0] block_bytes(input logic [4:0] n);
    return {25'd0, n, 2'b00};
  endfunction

  // Lowest address of the block; beats always ascend from here.
  function automatic logic [31:0] first_addr(input logic [31:0] base,
                                             input logic        up,
                                             input logic        pre,
                                             input logic [4:0]  n);
    logic [31:0] span;
    span = block_bytes(n);
    case ({up, pre})
      2'b10:   return base;
      2'b11:   return base + c_WORD_BYTES;
      2'b00:   return base - span + c_WORD_BYTES;
      default: return base - span;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_control_ldst_seq_pick.sv
// ============================================================================
// Module  : core_control_ldst_pick
// Brief   : Lowest-set-bit index, valid flag and popcount of a 16-bit mask.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module core_control_ldst_pick (
  input  logic [15:0] i_mask,
  output logic [3:0]  o_idx,
  output logic        o_valid,
  output logic [4:0]  o_count
);

  always_comb begin
    o_idx   = 4'd0;
    o_valid = 1'b0;
    o_count = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx   = 4'(i);
        o_valid = 1'b1;
      end
    end
    for (int i = 0; i < 16; i++) begin
      o_count = o_count + {4'd0, i_mask[i]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/core_control_ldst_seq.sv
// ============================================================================
// Module  : core_control_ldst_seq
// Brief   : LDM/STM block-transfer sequencer issuing one word beat per register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module core_control_ldst_seq
  import core_control_ldst_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] reg_list,
  input  logic [31:0] base,
  input  logic        up,
  input  logic        pre,
  input  logic        load,
  input  logic        writeback,
  input  logic        mem_ready,
  input  logic        abort,
  output logic        mem_start,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [3:0]  mem_reg,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        wb_valid,
  output logic [31:0] wb_value
);

  ldst_seq_state r_state;
  logic [15:0]   r_mask;
  logic [31:0]   r_base;
  logic          r_up;
  logic          r_pre;
  logic          r_load;
  logic          r_wb;

  logic [15:0]   w_pick_mask;
  logic [3:0]    w_idx;
  logic          w_valid;
  logic [4:0]    w_count;

  // In XFER the picker looks ahead at the mask with the current beat removed.
  assign w_pick_mask = (r_state == LDST_XFER) ? (r_mask & ~(16'd1 << mem_reg)) : r_mask;

  core_control_ldst_pick u_pick (
    .i_mask  (w_pick_mask),
    .o_idx   (w_idx),
    .o_valid (w_valid),
    .o_count (w_count)
  );

  assign busy = (r_state != LDST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= LDST_IDLE;
      r_mask    <= 16'd0;
      r_base    <= 32'd0;
      r_up      <= 1'b0;
      r_pre     <= 1'b0;
      r_load    <= 1'b0;
      r_wb      <= 1'b0;
      mem_start <= 1'b0;
      mem_addr  <= 32'd0;
      mem_write <= 1'b0;
      mem_reg   <= 4'd0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      wb_valid  <= 1'b0;
      wb_value  <= 32'd0;
    end else begin
      done     <= 1'b0;
      aborted  <= 1'b0;
      wb_valid <= 1'b0;
      case (r_state)
        LDST_IDLE: begin
          if (start) begin
            r_mask  <= reg_list;
            r_base  <= base;
            r_up    <= up;
            r_pre   <= pre;
            r_load  <= load;
            r_wb    <= writeback;
            r_state <= LDST_SETUP;
          end
        end
        LDST_SETUP: begin
          wb_value <= r_up ? (r_base + block_bytes(w_count)) : (r_base - block_bytes(w_count));
          if (w_count == 5'd0) begin
            done    <= 1'b1;
            r_state <= LDST_IDLE;
          end else begin
            mem_start <= 1'b1;
            mem_addr  <= first_addr(r_base, r_up, r_pre, w_count);
            mem_reg   <= w_idx;
            mem_write <= !r_load;
            r_state   <= LDST_XFER;
          end
        end
        LDST_XFER: begin
          if (mem_ready) begin
            if (abort) begin
              mem_start <= 1'b0;
              r_mask    <= 16'd0;
              done      <= 1'b1;
              aborted   <= 1'b1;
              r_state   <= LDST_IDLE;
            end else begin
              r_mask <= w_pick_mask;
              if (w_valid) begin
                mem_addr <= mem_addr + c_WORD_BYTES;
                mem_reg  <= w_idx;
              end else begin
                mem_start <= 1'b0;
                if (r_wb) begin
                  wb_valid <= 1'b1;
                  r_state  <= LDST_WRITEBACK;
                end else begin
                  done    <= 1'b1;
                  r_state <= LDST_IDLE;
                end
              end
            end
          end
        end
        LDST_WRITEBACK: begin
          done    <= 1'b1;
          r_state <= LDST_IDLE;
        end
        default: r_state <= LDST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
